// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the RV32 base core. Holds the program counter,
// presents pc[AW-1:0] to instruction_memory (combinational read), and captures
// the returned word into the IF/ID register. The IF/ID register is offered to
// decode over a valid/ready handshake. Branch/jump resolution can redirect the
// PC at any time. A redirect flushes the IF/ID register and creates a
// one-cycle bubble.
//
// Parameters
//   MEM_SIZE    instruction memory size in bytes (AW = $clog2(MEM_SIZE))
//   INST_WIDTH  instruction word width
//   RESET_PC    PC value loaded on reset
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   o_imem_addr    byte address to instruction memory (pc[AW-1:0])
//   i_imem_inst    word returned by instruction memory
//   i_redirect     take i_redirect_pc as the new PC
//   i_redirect_pc  redirect target byte address
//   o_if_valid     IF/ID register holds a valid instruction
//   o_if_inst      IF/ID instruction
//   o_if_pc        PC of o_if_inst
//   i_id_ready     decode accepts IF/ID contents this cycle
//   o_misalign     one-cycle pulse after a redirect whose target had bits[1:0] != 0
//   o_fetch_cnt    number of instructions loaded into IF/ID (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int          MEM_SIZE   = 1024,
    parameter int          INST_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    localparam int         AW         = $clog2(MEM_SIZE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [AW-1:0]         o_imem_addr,
    input  logic [INST_WIDTH-1:0] i_imem_inst,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc,
    output logic                  o_if_valid,
    output logic [INST_WIDTH-1:0] o_if_inst,
    output logic [31:0]           o_if_pc,
    input  logic                  i_id_ready,
    output logic                  o_misalign,
    output logic [31:0]           o_fetch_cnt
);

    // Architectural state
    logic [31:0]           pc_q,        pc_d;
    logic                  if_valid_q,  if_valid_d;
    logic [INST_WIDTH-1:0] if_inst_q,   if_inst_d;
    logic [31:0]           if_pc_q,     if_pc_d;
    logic                  misalign_q,  misalign_d;
    logic [31:0]           fetch_cnt_q, fetch_cnt_d;

    // The IF/ID slot can take a new word when it is empty or being consumed.
    logic adv;
    assign adv = !if_valid_q || i_id_ready;

    // Next-state logic. Priority: redirect, then advance, otherwise stall (hold).
    always_comb begin
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        // Misalign is a pulse: it clears on every cycle without a misaligned redirect.
        misalign_d  = 1'b0;

        if (i_redirect) begin
            // Target is force-aligned to a word; the dropped low bits are
            // reported through the misalign pulse. The IF/ID payload keeps its
            // old value but is no longer valid.
            pc_d       = {i_redirect_pc[31:2], 2'b00};
            if_valid_d = 1'b0;
            misalign_d = (i_redirect_pc[1:0] != 2'b00);
        end else if (adv) begin
            if_inst_d   = i_imem_inst;
            if_pc_d     = pc_q;
            if_valid_d  = 1'b1;
            pc_d        = pc_q + 32'd4;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            if_pc_q     <= '0;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            misalign_q  <= misalign_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Upper PC bits are ignored, so fetch addresses alias modulo MEM_SIZE.
    assign o_imem_addr = pc_q[AW-1:0];
    assign o_if_valid  = if_valid_q;
    assign o_if_inst   = if_inst_q;
    assign o_if_pc     = if_pc_q;
    assign o_misalign  = misalign_q;
    assign o_fetch_cnt = fetch_cnt_q;

endmodule
